// File: rtl/sched_pkg.sv
// Shared types and index helpers for the schedule dispatcher.
// The flat assignment and frequency buses are decoded with the helpers below.
package sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_FIN   = 2'd3
   } state_e;

   function automatic int tid_width(input int num_tasks);
      return (num_tasks > 1) ? $clog2(num_tasks) : 1;
   endfunction

   function automatic int cid_width(input int num_procs);
      return (num_procs > 1) ? $clog2(num_procs) : 1;
   endfunction

   // Bit p*NUM_TASKS+t of processor_assignment means task t runs on core p.
   function automatic int asg_bit(input int p, input int t, input int num_tasks);
      return p * num_tasks + t;
   endfunction

   function automatic int freq_lsb(input int t, input int data_width);
      return t * data_width;
   endfunction

endpackage

// File: rtl/schedule_dispatcher_if.sv
// Dispatch channel from the dispatcher (master) to the core cluster (slave).
interface schedule_dispatcher_if
   import sched_pkg::*;
#(
   parameter int TID_W      = 4,
   parameter int CID_W      = 2,
   parameter int DATA_WIDTH = 32
);
   logic                  disp_valid;
   logic                  disp_ready;
   logic [TID_W-1:0]      disp_task;
   logic [CID_W-1:0]      disp_core;
   logic [DATA_WIDTH-1:0] disp_freq;

   modport master (output disp_valid, disp_task, disp_core, disp_freq, input disp_ready);
   modport slave  (input disp_valid, disp_task, disp_core, disp_freq, output disp_ready);
endinterface

// File: rtl/schedule_dispatcher_onehot_to_index.sv
// Lowest-set-bit encoder for a core mask, with empty and multi-hot flags.
module onehot_to_index
   import sched_pkg::*;
#(
   parameter int N = 3,
   parameter int W = 2
) (
   input  logic [N-1:0] mask_i,
   output logic [W-1:0] index_o,
   output logic         none_o,
   output logic         multi_o
);

   always_comb begin
      index_o = '0;
      for (int p = N - 1; p >= 0; p--) begin
         if (mask_i[p]) index_o = W'(p);
      end
   end

   assign none_o  = ~|mask_i;
   assign multi_o = |(mask_i & (mask_i - N'(1)));

endmodule

// File: rtl/schedule_dispatcher.sv
// Issues captured schedule tasks in index order to their cores over a
// valid/ready channel, tracks per-core occupancy and reports the makespan.
module schedule_dispatcher
   import sched_pkg::*;
#(
   parameter int NUM_TASKS      = 10,
   parameter int NUM_PROCESSORS = 3,
   parameter int DATA_WIDTH     = 32,
   parameter int TID_W          = tid_width(NUM_TASKS),
   parameter int CID_W          = cid_width(NUM_PROCESSORS)
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  start,
   input  logic [0:NUM_PROCESSORS*NUM_TASKS-1]   processor_assignment,
   input  logic [0:DATA_WIDTH*NUM_TASKS-1]       freq_in,
   schedule_dispatcher_if.master                 disp,
   input  logic [NUM_PROCESSORS-1:0]             core_done,
   output logic [NUM_PROCESSORS-1:0]             core_busy,
   output logic                                  busy,
   output logic                                  all_done,
   output logic [DATA_WIDTH-1:0]                 cycle_count,
   output logic                                  err_unassigned,
   output logic                                  err_multi,
   output logic                                  err_spurious
);

   localparam logic [TID_W-1:0] LAST_IDX = TID_W'(NUM_TASKS - 1);

   state_e                              state_q;
   logic [TID_W-1:0]                    idx_q;
   logic [0:NUM_PROCESSORS*NUM_TASKS-1] asg_q;
   logic [0:DATA_WIDTH*NUM_TASKS-1]     freq_q;
   logic [NUM_PROCESSORS-1:0]           core_busy_q, core_busy_d;
   logic [DATA_WIDTH-1:0]               cycle_q;
   logic                                err_unassigned_q, err_multi_q, err_spurious_q;
   logic                                all_done_q;

   logic [NUM_PROCESSORS-1:0] mask_all [NUM_TASKS];
   logic [DATA_WIDTH-1:0]     freq_all [NUM_TASKS];
   logic [NUM_PROCESSORS-1:0] mask;
   logic [CID_W-1:0]          core;
   logic                      none, multi;
   logic                      valid, xfer, skip, spurious;

   function automatic logic [DATA_WIDTH-1:0] sat_inc(input logic [DATA_WIDTH-1:0] v);
      return (&v) ? v : v + DATA_WIDTH'(1);
   endfunction

   for (genvar t = 0; t < NUM_TASKS; t++) begin : g_task
      assign freq_all[t] = freq_q[freq_lsb(t, DATA_WIDTH) +: DATA_WIDTH];
      for (genvar p = 0; p < NUM_PROCESSORS; p++) begin : g_core
         assign mask_all[t][p] = asg_q[asg_bit(p, t, NUM_TASKS)];
      end
   end

   assign mask = mask_all[idx_q];

   onehot_to_index #(.N(NUM_PROCESSORS), .W(CID_W)) u_core_sel (
      .mask_i  (mask),
      .index_o (core),
      .none_o  (none),
      .multi_o (multi)
   );

   // Gated by the registered busy bit only, so ready never feeds back into valid.
   assign valid    = (state_q == ST_ISSUE) && !none && !core_busy_q[core];
   assign xfer     = valid && disp.disp_ready;
   assign skip     = (state_q == ST_ISSUE) && none;
   assign spurious = |(core_done & ~core_busy_q);
   assign core_busy_d = (core_busy_q & ~core_done)
                      | (xfer ? (NUM_PROCESSORS'(1) << core) : '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q          <= ST_IDLE;
         idx_q            <= '0;
         asg_q            <= '0;
         freq_q           <= '0;
         core_busy_q      <= '0;
         cycle_q          <= '0;
         err_unassigned_q <= 1'b0;
         err_multi_q      <= 1'b0;
         err_spurious_q   <= 1'b0;
         all_done_q       <= 1'b0;
      end else begin
         all_done_q  <= 1'b0;
         core_busy_q <= core_busy_d;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  asg_q            <= processor_assignment;
                  freq_q           <= freq_in;
                  idx_q            <= '0;
                  cycle_q          <= '0;
                  err_unassigned_q <= 1'b0;
                  err_multi_q      <= 1'b0;
                  err_spurious_q   <= 1'b0;
                  state_q          <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               cycle_q <= sat_inc(cycle_q);
               if (skip)  err_unassigned_q <= 1'b1;
               if (multi) err_multi_q      <= 1'b1;
               if (skip || xfer) begin
                  if (idx_q == LAST_IDX) state_q <= ST_DRAIN;
                  else                   idx_q   <= idx_q + TID_W'(1);
               end
            end
            ST_DRAIN: begin
               cycle_q <= sat_inc(cycle_q);
               if (core_busy_q == '0) begin
                  state_q    <= ST_FIN;
                  all_done_q <= 1'b1;
               end
            end
            ST_FIN:  state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
         // Last assignment wins, so a completion for an idle core survives a start clear.
         if (spurious) err_spurious_q <= 1'b1;
      end
   end

   assign disp.disp_valid = valid;
   assign disp.disp_task  = idx_q;
   assign disp.disp_core  = core;
   assign disp.disp_freq  = freq_all[idx_q];
   assign core_busy       = core_busy_q;
   assign busy            = (state_q != ST_IDLE);
   assign all_done        = all_done_q;
   assign cycle_count     = cycle_q;
   assign err_unassigned  = err_unassigned_q;
   assign err_multi       = err_multi_q;
   assign err_spurious    = err_spurious_q;

endmodule

// File: tb/tb_schedule_dispatcher.sv
// Randomized scoreboard bench for schedule_dispatcher with a task-level reference model.
module tb_schedule_dispatcher;
   localparam int NT = 10;
   localparam int NP = 3;
   localparam int DW = 32;

   logic                clk = 1'b0;
   logic                reset, start;
   logic [0:NP*NT-1]    asg;
   logic [0:DW*NT-1]    fr;
   logic [NP-1:0]       core_done, core_busy;
   logic                busy, all_done, err_u, err_m, err_s;
   logic [DW-1:0]       cycle_count;

   schedule_dispatcher_if #(.TID_W(4), .CID_W(2), .DATA_WIDTH(DW)) dif ();

   schedule_dispatcher #(.NUM_TASKS(NT), .NUM_PROCESSORS(NP), .DATA_WIDTH(DW)) dut (
      .clk(clk), .reset(reset), .start(start),
      .processor_assignment(asg), .freq_in(fr),
      .disp(dif.master),
      .core_done(core_done), .core_busy(core_busy), .busy(busy),
      .all_done(all_done), .cycle_count(cycle_count),
      .err_unassigned(err_u), .err_multi(err_m), .err_spurious(err_s)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          tid;
      int          core;
      logic [DW-1:0] freq;
   } exp_t;
   exp_t expq[$];

   int n_checks = 0, n_fail = 0;
   int cyc = 0, start_cyc = 0, done_cnt = 0, max_gap = 0, stall = 0;
   int hold_cnt = 0, xfer_core = 0;
   int dly[NP];
   int cnt[NP];
   bit xfer_pend = 0, rand_ready = 0, conc_seen = 0, prev_hold = 0;
   bit exp_u = 0, exp_m = 0, spur_exp = 0;
   logic [NP-1:0] inject = '0, model_busy = '0;
   logic [DW-1:0] last_cc = '0, prev_freq = '0;
   logic [3:0] prev_task = '0;
   logic [1:0] prev_core = '0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_valid"}, dif.disp_valid, 0);
      chk({tag, "_task"}, dif.disp_task, 0);
      chk({tag, "_core"}, dif.disp_core, 0);
      chk({tag, "_freq"}, dif.disp_freq, 0);
      chk({tag, "_core_busy"}, core_busy, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_all_done"}, all_done, 0);
      chk({tag, "_cycle_count"}, cycle_count, 0);
      chk({tag, "_errs"}, {err_u, err_m, err_s}, 0);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Core cluster: completes each dispatched task after a per-core delay.
   initial begin
      core_done = '0;
      dif.disp_ready = 1'b1;
      forever begin
         logic [NP-1:0] d;
         @(posedge clk);
         #1;
         if (reset) begin
            for (int p = 0; p < NP; p++) cnt[p] = 0;
            core_done = '0;
            xfer_pend = 0;
         end else begin
            d = inject;
            inject = '0;
            for (int p = 0; p < NP; p++) begin
               if (cnt[p] > 0) begin
                  cnt[p]--;
                  if (cnt[p] == 0) d[p] = 1'b1;
               end
            end
            if (xfer_pend) begin
               cnt[xfer_core] = dly[xfer_core];
               xfer_pend = 0;
            end
            core_done = d;
         end
         if (hold_cnt > 0) begin
            hold_cnt--;
            dif.disp_ready = 1'b0;
         end else begin
            dif.disp_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
         end
      end
   end

   // Monitor: occupancy model, ordering scoreboard and completion checks.
   initial forever begin
      logic [NP-1:0] nb;
      bit spur_new;
      @(negedge clk);
      if (reset) begin
         model_busy = '0; spur_exp = 0; prev_hold = 0; stall = 0;
      end else begin
         chk("core_busy", core_busy, model_busy);
         chk("err_spurious", err_s, spur_exp);
         if (prev_hold) begin
            chk("hold_valid", dif.disp_valid, 1);
            chk("hold_task", dif.disp_task, prev_task);
            chk("hold_core", dif.disp_core, prev_core);
            chk("hold_freq", dif.disp_freq, prev_freq);
         end
         if (dif.disp_valid) chk("target_free", model_busy[dif.disp_core], 0);
         if (busy && expq.size() > 0 && !model_busy[expq[0].core] && !dif.disp_valid) begin
            stall++;
            chk("issue_gap", stall <= max_gap, 1);
         end else begin
            stall = 0;
         end
         if (start && !busy) begin
            spur_exp = 0;
            start_cyc = cyc;
         end
         nb = model_busy;
         spur_new = 0;
         for (int p = 0; p < NP; p++) begin
            if (core_done[p]) begin
               if (model_busy[p]) nb[p] = 1'b0;
               else spur_new = 1;
            end
         end
         if (dif.disp_valid && dif.disp_ready) begin
            if (expq.size() == 0) begin
               chk("unexpected_dispatch", dif.disp_task, 15);
            end else begin
               exp_t e;
               e = expq.pop_front();
               chk("disp_task", dif.disp_task, e.tid);
               chk("disp_core", dif.disp_core, e.core);
               chk("disp_freq", dif.disp_freq, e.freq);
            end
            for (int p = 0; p < NP; p++)
               if (core_done[p] && model_busy[p] && p != int'(dif.disp_core)) conc_seen = 1;
            nb[dif.disp_core] = 1'b1;
            xfer_pend = 1;
            xfer_core = int'(dif.disp_core);
         end
         model_busy = nb;
         spur_exp = spur_exp | spur_new;
         prev_hold = dif.disp_valid && !dif.disp_ready;
         prev_task = dif.disp_task;
         prev_core = dif.disp_core;
         prev_freq = dif.disp_freq;
         if (all_done) begin
            done_cnt++;
            last_cc = DW'(cyc - start_cyc - 1);
            chk("done_core_busy", core_busy, 0);
            chk("done_queue_left", expq.size(), 0);
            chk("done_err_unassigned", err_u, exp_u);
            chk("done_err_multi", err_m, exp_m);
            chk("done_cycle_count", cycle_count, last_cc);
         end
      end
   end

   task automatic set_mod3();
      asg = '0;
      for (int t = 0; t < NT; t++) begin
         asg[(t % NP) * NT + t] = 1'b1;
         fr[t * DW +: DW] = DW'(500 + 100 * t);
      end
   endtask

   task automatic run_sched(input int hold, input bit abort5);
      int d0;
      bit ok;
      exp_u = 0; exp_m = 0; max_gap = 0;
      for (int t = 0; t < NT; t++) begin
         int n, first;
         exp_t e;
         n = 0; first = -1;
         for (int p = 0; p < NP; p++) begin
            if (asg[p * NT + t]) begin
               n++;
               if (first < 0) first = p;
            end
         end
         if (n == 0) begin
            exp_u = 1;
            max_gap++;
         end else begin
            if (n > 1) exp_m = 1;
            e.tid = t; e.core = first; e.freq = fr[t * DW +: DW];
            expq.push_back(e);
         end
      end
      d0 = done_cnt;
      @(posedge clk); #2;
      start = 1'b1;
      hold_cnt = hold;
      @(posedge clk); #2;
      start = 1'b0;
      ok = 0;
      if (abort5) begin
         for (int k = 0; k < 500; k++) begin
            if (dif.disp_valid && dif.disp_task == 4'd5) begin
               ok = 1;
               break;
            end
            @(posedge clk); #2;
         end
         chk("reach_task5", ok, 1);
         reset = 1'b1;
         #1;
         check_zero("midrun_reset");
         expq.delete();
         repeat (2) @(posedge clk);
         #2;
         reset = 1'b0;
         chk("no_all_done_on_reset", done_cnt, d0);
      end else begin
         for (int k = 0; k < 3000; k++) begin
            @(posedge clk); #2;
            if (done_cnt != d0) begin
               ok = 1;
               break;
            end
         end
         chk("all_done_seen", ok, 1);
         if (!ok) expq.delete();
         repeat (3) @(posedge clk);
         #2;
         chk("all_done_once", done_cnt, d0 + 1);
         chk("cycle_count_held", cycle_count, last_cc);
         chk("idle_after_fin", busy, 0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; start = 1'b0; asg = '0; fr = '0;
      dly = '{2, 2, 2};
      repeat (3) @(posedge clk);
      #2;
      check_zero("reset");
      reset = 1'b0;

      // Completion for an idle core.
      @(posedge clk); #2;
      inject = 3'b100;
      repeat (3) @(posedge clk);
      #2;
      chk("spurious_idle", err_s, 1);

      set_mod3();
      run_sched(0, 0);

      // Head-of-line: tasks 0 and 1 share core 0.
      set_mod3();
      asg[1 * NT + 1] = 1'b0; asg[0 * NT + 1] = 1'b1;
      dly = '{5, 2, 2};
      run_sched(0, 0);

      set_mod3();
      dly = '{2, 2, 2};
      run_sched(4, 0);

      // Task 3 unassigned, task 4 on cores 1 and 2.
      set_mod3();
      asg[0 * NT + 3] = 1'b0;
      asg[2 * NT + 4] = 1'b1;
      run_sched(0, 0);
      chk("malformed_unassigned", err_u, 1);
      chk("malformed_multi", err_m, 1);

      // Core 0 completes in the same cycle task 2 goes to core 1.
      set_mod3();
      asg[1 * NT + 1] = 1'b0; asg[2 * NT + 1] = 1'b1;
      asg[2 * NT + 2] = 1'b0; asg[1 * NT + 2] = 1'b1;
      dly = '{1, 2, 2};
      conc_seen = 0;
      run_sched(0, 0);
      chk("concurrent_done_xfer", conc_seen, 1);

      // Every task skipped: ten ISSUE cycles plus one DRAIN cycle.
      asg = '0;
      run_sched(0, 0);
      chk("cycle_count_all_skip", cycle_count, 11);

      set_mod3();
      dly = '{2, 2, 2};
      run_sched(0, 1);
      run_sched(0, 0);

      rand_ready = 1;
      for (int r = 0; r < 6; r++) begin
         asg = '0;
         for (int t = 0; t < NT; t++) begin
            int x, a, b;
            x = $urandom_range(0, 9);
            a = $urandom_range(0, NP - 1);
            b = (a + $urandom_range(1, NP - 1)) % NP;
            if (x == 1) begin
               asg[a * NT + t] = 1'b1;
               asg[b * NT + t] = 1'b1;
            end else if (x != 0) begin
               asg[a * NT + t] = 1'b1;
            end
            fr[t * DW +: DW] = $urandom;
         end
         for (int p = 0; p < NP; p++) dly[p] = $urandom_range(1, 6);
         run_sched($urandom_range(0, 3), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
